// File: rtl/mips_lsu_pkg.sv
// Shared MIPS core definitions: opcode/funct constants, register-index width
// and the load/store unit FSM encoding.
package mips_lsu_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] OPCODE_J     = 6'h02;
  localparam logic [5:0] OPCODE_JAL   = 6'h03;
  localparam logic [5:0] OPCODE_BEQ   = 6'h04;
  localparam logic [5:0] OPCODE_BNE   = 6'h05;
  localparam logic [5:0] OPCODE_ADDI  = 6'h08;
  localparam logic [5:0] OPCODE_ANDI  = 6'h0c;
  localparam logic [5:0] OPCODE_ORI   = 6'h0d;
  localparam logic [5:0] OPCODE_LUI   = 6'h0f;
  localparam logic [5:0] OPCODE_LW    = 6'h23;
  localparam logic [5:0] OPCODE_SW    = 6'h2b;

  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_JR  = 6'h08;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2a;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_REQ    = 2'd1,
    LSU_WAIT_R = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/mips_lsu.sv
// MIPS load/store unit: one outstanding word access on a req/gnt + rvalid port.
// Optional MIPS_LSU_ALIGN_CHECK_EN flags misaligned addresses instead of issuing them.
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [REG_IDX_W-1:0] req_rd,
  output logic                 stall,
  output logic                 resp_valid,
  output logic [DATA_W-1:0]    resp_rdata,
  output logic [REG_IDX_W-1:0] resp_rd,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [DATA_W-1:0]    mem_rdata
`ifdef MIPS_LSU_ALIGN_CHECK_EN
  ,
  output logic                 err_valid,
  output logic [ADDR_W-1:0]    err_addr
`endif
);

  lsu_state_e state, state_nxt;

  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [REG_IDX_W-1:0] rd_q;
  logic                 accept;
  logic                 resp_fire;
  logic                 misalign;
  logic                 idle_ready;

`ifdef MIPS_LSU_ALIGN_CHECK_EN
  logic err_fire;
  assign misalign   = |req_addr[1:0];
  // the cycle after a rejected access is spent reporting it, not accepting
  assign idle_ready = ~err_valid;
`else
  assign misalign   = 1'b0;
  assign idle_ready = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= LSU_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    accept    = 1'b0;
    resp_fire = 1'b0;
    unique case (state)
      LSU_IDLE: begin
        req_ready = idle_ready;
        if (req_valid && idle_ready && !misalign) begin
          accept    = 1'b1;
          state_nxt = LSU_REQ;
        end
      end
      LSU_REQ: begin
        mem_req = 1'b1;
        mem_we  = we_q;
        if (mem_gnt) state_nxt = we_q ? LSU_IDLE : LSU_WAIT_R;
      end
      LSU_WAIT_R: begin
        if (mem_rvalid) begin
          resp_fire = 1'b1;
          state_nxt = LSU_IDLE;
        end
      end
      default: state_nxt = LSU_IDLE;
    endcase
  end

`ifdef MIPS_LSU_ALIGN_CHECK_EN
  assign err_fire = (state == LSU_IDLE) && req_valid && idle_ready && misalign;
`endif

  assign stall = req_valid & ~req_ready;

  // latched request; address is word-aligned by dropping the byte offset
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
      wdata_q <= req_wdata;
      rd_q    <= req_rd;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_rd    <= '0;
    end else begin
      resp_valid <= resp_fire;
      if (resp_fire) begin
        resp_rdata <= mem_rdata;
        resp_rd    <= rd_q;
      end
    end
  end

`ifdef MIPS_LSU_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else begin
      err_valid <= err_fire;
      if (err_fire) err_addr <= req_addr;
    end
  end
`endif

endmodule

// File: tb/tb_mips_lsu.sv
// Directed-vector bench for mips_lsu; align-check vectors run when
// MIPS_LSU_ALIGN_CHECK_EN is defined.
module tb_mips_lsu;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [4:0]    req_rd;
  logic          stall;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic [4:0]    resp_rd;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt, mem_rvalid;
  logic [DW-1:0] mem_rdata;
`ifdef MIPS_LSU_ALIGN_CHECK_EN
  logic          err_valid;
  logic [AW-1:0] err_addr;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_gnt = 0;
  int n_rsp = 0;

  always #5 clk = ~clk;

  mips_lsu #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .stall(stall),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef MIPS_LSU_ALIGN_CHECK_EN
    , .err_valid(err_valid), .err_addr(err_addr)
`endif
  );

  // count real memory handshakes and responses to catch lost/duplicated accesses
  always @(posedge clk) begin
    if (!reset && mem_req && mem_gnt) n_gnt++;
    if (!reset && resp_valid) n_rsp++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // inputs change 1ns after the edge, outputs are sampled 1ns later
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [4:0] rd);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_rd = rd;
  endtask

  initial begin
    reset = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    drive(1'b0, 1'b0, '0, '0, '0);
    tick(); tick(); settle();

    // reset state
    chk("rst_ready", req_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_rd", resp_rd, 0);
`ifdef MIPS_LSU_ALIGN_CHECK_EN
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_addr", err_addr, 0);
`endif
    tick(); reset = 1'b0;

    // store, grant tied high: one-cycle request, no response
    mem_gnt = 1'b1;
    drive(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 5'd0); settle();
    chk("st_n_ready", req_ready, 1);
    chk("st_n_stall", stall, 0);
    chk("st_n_mem_req", mem_req, 0);
    tick(); drive(1'b0, 1'b0, '0, '0, '0); settle();
    chk("st_n1_mem_req", mem_req, 1);
    chk("st_n1_mem_we", mem_we, 1);
    chk("st_n1_addr", mem_addr, 32'h10);
    chk("st_n1_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_n1_ready", req_ready, 0);
    tick(); settle();
    chk("st_n2_mem_req", mem_req, 0);
    chk("st_n2_ready", req_ready, 1);
    chk("st_n2_resp", resp_valid, 0);
    tick(); settle();
    chk("st_n3_resp", resp_valid, 0);
    mem_gnt = 1'b0;

    // load: grant after 3 waiting cycles, rvalid two cycles after grant
    drive(1'b1, 1'b0, 32'h24, 32'h0, 5'd5); settle();
    chk("ld_accept_stall", stall, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      chk("ld_req_wait", mem_req, 1);
      chk("ld_req_stall", stall, 1);
      chk("ld_req_addr", mem_addr, 32'h24);
    end
    tick(); mem_gnt = 1'b1; settle();
    chk("ld_gnt_req", mem_req, 1);
    chk("ld_gnt_we", mem_we, 0);
    tick(); mem_gnt = 1'b0; settle();
    chk("ld_w1_req", mem_req, 0);
    chk("ld_w1_stall", stall, 1);
    tick(); mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; settle();
    chk("ld_w2_stall", stall, 1);
    chk("ld_w2_resp", resp_valid, 0);
    tick(); mem_rvalid = 1'b0; mem_rdata = '0; drive(1'b0, 1'b0, '0, '0, '0); settle();
    chk("ld_resp_valid", resp_valid, 1);
    chk("ld_resp_rdata", resp_rdata, 32'h1234_5678);
    chk("ld_resp_rd", resp_rd, 5);
    tick(); settle();
    chk("ld_resp_pulse", resp_valid, 0);
    chk("ld_resp_hold", resp_rdata, 32'h1234_5678);

    // back-to-back: SW held valid while LW completes, accepted on resp cycle
    mem_gnt = 1'b1;
    drive(1'b1, 1'b0, 32'h40, 32'h0, 5'd7);
    tick(); drive(1'b1, 1'b1, 32'h80, 32'hCAFE_0001, 5'd0); settle();
    chk("b2b_ld_addr", mem_addr, 32'h40);
    chk("b2b_ld_we", mem_we, 0);
    chk("b2b_sw_stall", stall, 1);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0F0F; settle();
    chk("b2b_wait_req", mem_req, 0);
    tick(); mem_rvalid = 1'b0; settle();
    chk("b2b_resp_valid", resp_valid, 1);
    chk("b2b_resp_rdata", resp_rdata, 32'hA5A5_0F0F);
    chk("b2b_resp_rd", resp_rd, 7);
    chk("b2b_sw_ready", req_ready, 1);
    tick(); drive(1'b0, 1'b0, '0, '0, '0); mem_gnt = 1'b1; settle();
    chk("b2b_sw_req", mem_req, 1);
    chk("b2b_sw_we", mem_we, 1);
    chk("b2b_sw_addr", mem_addr, 32'h80);
    chk("b2b_sw_wdata", mem_wdata, 32'hCAFE_0001);
    tick(); mem_gnt = 1'b0; settle();
    chk("b2b_done_req", mem_req, 0);
    chk("b2b_done_resp", resp_valid, 0);
    chk("b2b_n_gnt", n_gnt, 4);
    chk("b2b_n_rsp", n_rsp, 2);

`ifndef MIPS_LSU_ALIGN_CHECK_EN
    // without alignment checking the byte offset is silently dropped
    drive(1'b1, 1'b1, 32'h13, 32'h0000_0055, 5'd0);
    tick(); drive(1'b0, 1'b0, '0, '0, '0); mem_gnt = 1'b1; settle();
    chk("unal_addr", mem_addr, 32'h10);
    chk("unal_req", mem_req, 1);
    tick(); mem_gnt = 1'b0; settle();
`endif

    // reset while waiting for read data; late rvalid must be dropped
    mem_gnt = 1'b1;
    drive(1'b1, 1'b0, 32'h100, 32'h0, 5'd3);
    tick(); drive(1'b0, 1'b0, '0, '0, '0);
    tick(); mem_gnt = 1'b0; settle();
    chk("rw_in_wait", mem_req, 0);
    reset = 1'b1;
    tick(); reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0; settle();
    chk("rw_ready", req_ready, 1);
    chk("rw_mem_req", mem_req, 0);
    chk("rw_mem_addr", mem_addr, 0);
    chk("rw_mem_wdata", mem_wdata, 0);
    chk("rw_resp_rdata", resp_rdata, 0);
    chk("rw_resp_rd", resp_rd, 0);
    tick(); mem_rvalid = 1'b0; settle();
    chk("rw_no_resp", resp_valid, 0);
    chk("rw_ready2", req_ready, 1);

    // spurious gnt/rvalid while idle
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    tick(); tick(); settle();
    chk("spur_mem_req", mem_req, 0);
    chk("spur_resp", resp_valid, 0);
    chk("spur_ready", req_ready, 1);
    chk("spur_rdata", resp_rdata, 0);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;

`ifdef MIPS_LSU_ALIGN_CHECK_EN
    // misaligned load is reported and never reaches memory
    mem_gnt = 1'b1;
    drive(1'b1, 1'b0, 32'h6, 32'h0, 5'd9); settle();
    chk("al_n_ready", req_ready, 1);
    tick(); drive(1'b0, 1'b0, '0, '0, '0); settle();
    chk("al_err_valid", err_valid, 1);
    chk("al_err_addr", err_addr, 32'h6);
    chk("al_ready", req_ready, 0);
    chk("al_mem_req", mem_req, 0);
    tick(); settle();
    chk("al_err_pulse", err_valid, 0);
    chk("al_mem_req2", mem_req, 0);
    chk("al_ready2", req_ready, 1);
    chk("al_resp", resp_valid, 0);
    mem_gnt = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
